cim_pad_sequencer: RTL and testbench
====================================

# cim_pad_sequencer

Pad-side sequencer for the 45-pin external CIM macro interface. It takes a 64-bit wordline vector from the SoC core and pushes it out in eight 8-bit groups with latch strobes. It then pulses `cim_start`, waits for `cim_done`, and scans 32 bitline channels through the `bl_sel`/`bl_data` pins, streaming one 8-bit result per channel back to the core. It sits between the core's CIM request logic and the chip pad ring, and drives the `wl_*`, `cim_start` and `bl_sel` pads directly.

## Interface
- `WL_GROUPS`, 8: wordline groups per request; must be ≤ 8 because `wl_group_sel` is 3 bits.
- `BL_CH`, 32: bitline channels scanned; must be ≤ 32 because `bl_sel` is 5 bits.
- `SETUP_CYC`, 1: cycles `wl_data`/`wl_group_sel` are held before the latch strobe; must be ≥ 1.
- `LATCH_CYC`, 1: width of the `wl_latch` high pulse in cycles; must be ≥ 1.
- `BL_SETTLE_CYC`, 2: cycles after a `bl_sel` change before `bl_data` is sampled; must be ≥ 1.
- `DONE_TIMEOUT`, 1023: maximum cycles spent in WAIT_DONE; only used when the timeout macro is defined.

- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  high only in IDLE.
- `req_wl`  in  WL_GROUPS*8  wordline vector; group g is `req_wl[g*8+:8]`.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result accept.
- `res_idx`  out  5  channel index of the current result.
- `res_data`  out  8  sampled bitline value.
- `res_last`  out  1  equals `res_valid && res_idx == BL_CH-1`.
- `busy`  out  1  high whenever the state is not IDLE.
- `timeout_err`  out  1  one-cycle pulse when the done-wait times out.
- `wl_data`  out  8  wordline data pad.
- `wl_group_sel`  out  3  wordline group select pad.
- `wl_latch`  out  1  wordline latch strobe pad.
- `cim_start`  out  1  compute start pad.
- `cim_done`  in  1  asynchronous pad input; passes through a 2-flop synchronizer.
- `bl_sel`  out  5  bitline channel select pad.
- `bl_data`  in  8  bitline data pad; quasi-static once settled.

## Operation
- States: IDLE, WL_SETUP, WL_LATCH, START, WAIT_DONE, BL_SETTLE, BL_OUT.
- **IDLE**
  - On `req_valid && req_ready`: register `req_wl` into the internal buffer, set group to 0, go to WL_SETUP.
- **WL_SETUP**
  - Drive `wl_data = buf[group*8+:8]` and `wl_group_sel = group` for SETUP_CYC cycles, then go to WL_LATCH.
- **WL_LATCH**
  - Hold `wl_data` and `wl_group_sel`; drive `wl_latch = 1` for LATCH_CYC cycles.
  - Then: if `group == WL_GROUPS-1`, go to START; otherwise increment group and go to WL_SETUP.
- **START**
  - Drive `cim_start = 1` for exactly one cycle.
  - Clear the timer, set channel to 0, go to WAIT_DONE.
- **WAIT_DONE**
  - Wait for a rising edge of the synchronized done (`sync && !sync_q`). A level that was already high on entry is ignored.
  - On the edge, go to BL_SETTLE.
- **BL_SETTLE**
  - Drive `bl_sel = channel` for BL_SETTLE_CYC cycles.
  - Register `bl_data` into the result register on the last settle cycle, then go to BL_OUT.
- **BL_OUT**
  - Drive `res_valid = 1`, `res_idx = channel`, and `res_data` from the held register.
  - Hold all of these stable until `res_ready`.
  - On the handshake: if `channel == BL_CH-1`, go to IDLE; otherwise increment channel and go to BL_SETTLE.
- `bl_sel` holds its last value outside BL_SETTLE/BL_OUT.
- `wl_data` and `wl_group_sel` return to 0 in IDLE.
- `req_wl` is sampled only at acceptance; later changes have no effect.
- `res_ready` outside BL_OUT is ignored.

## Timing
- Reset values: all outputs are 0, except `req_ready = 1`. State goes to IDLE and the synchronizer flops clear.
- Reset mid-operation: on the next edge `wl_latch`, `cim_start` and `res_valid` drop and the current result is discarded.
- All pad outputs are driven directly from flops, with no combinational path from any input.
- Acceptance at edge T0 puts the first `wl_data` on the pad at T0+1. `cim_start` goes high in cycle T0+1+WL_GROUPS*(SETUP_CYC+LATCH_CYC), which is T0+17 with default parameters.
- A `cim_done` rising edge reaches the FSM 2 cycles after it is registered by the first synchronizer flop.
- Each channel takes BL_SETTLE_CYC cycles plus the wait in BL_OUT. With `res_ready` tied high this is 3 cycles per channel, so a full scan takes 96 cycles.
- Back-to-back requests: `req_ready` rises in the cycle after the last result handshake.

## Configuration
- `CIM_PAD_SEQ_TIMEOUT_EN` defined:
  - WAIT_DONE counts cycles.
  - If the count reaches DONE_TIMEOUT with no done edge, `timeout_err` pulses for 1 cycle and the FSM returns to IDLE with no results emitted.
  - A done edge arriving in the same cycle as the limit wins: no error is raised.
- Not defined:
  - No counter is built, `timeout_err` is tied to 0, and WAIT_DONE waits indefinitely.

## Test plan
- **Wordline sequence:** `req_wl = 64'h0807_0605_0403_0201` → eight latch pulses with `wl_group_sel` 0..7 and `wl_data` 01..08, each stable for 2 cycles; `cim_start` rises at T0+17.
- **Full scan:** `cim_done` edge, `bl_data = 8'hA0 + bl_sel`, `res_ready = 1` → 32 results, `res_idx` 0..31, `res_data` A0..BF, `res_last` only on idx 31, then `req_ready = 1`.
- **Backpressure:** `res_ready` low for 5 cycles at idx 3 → `res_valid`, `res_idx = 3` and `res_data` stay stable, and `bl_sel` does not advance.
- **Stale done:** `cim_done` already high when WAIT_DONE is entered → no progress until `cim_done` falls and rises again.
- **Timeout (macro on, `DONE_TIMEOUT = 20`):** no `cim_done` → `timeout_err` high for 1 cycle, `busy` falls, no `res_valid`.
- **Reset mid-latch:** `rst` asserted while `wl_latch = 1` → next cycle all outputs are 0, `req_ready = 1`, and a new request runs normally.

Source files
------------

// File: rtl/cim_pad_sequencer.sv
// Pad-side CIM sequencer: shifts a wordline vector out in 8-bit groups, starts the macro, scans bitline results.
// Optional done-wait timeout is built when CIM_PAD_SEQ_TIMEOUT_EN is defined.
module cim_pad_sequencer #(
  parameter int WL_GROUPS     = 8,
  parameter int BL_CH         = 32,
  parameter int SETUP_CYC     = 1,
  parameter int LATCH_CYC     = 1,
  parameter int BL_SETTLE_CYC = 2,
  parameter int DONE_TIMEOUT  = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WL_GROUPS*8-1:0] req_wl,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4:0]             res_idx,
  output logic [7:0]             res_data,
  output logic                   res_last,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [7:0]             wl_data,
  output logic [2:0]             wl_group_sel,
  output logic                   wl_latch,
  output logic                   cim_start,
  input  logic                   cim_done,
  output logic [4:0]             bl_sel,
  input  logic [7:0]             bl_data
);

  if (WL_GROUPS < 1 || WL_GROUPS > 8) begin : g_bad_groups
    $error("WL_GROUPS must be 1..8");
  end
  if (BL_CH < 1 || BL_CH > 32) begin : g_bad_ch
    $error("BL_CH must be 1..32");
  end
  if (SETUP_CYC < 1 || LATCH_CYC < 1 || BL_SETTLE_CYC < 1 || DONE_TIMEOUT < 1) begin : g_bad_cyc
    $error("cycle parameters must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE, WL_SETUP, WL_LATCH, START, WAIT_DONE, BL_SETTLE, BL_OUT
  } state_t;

  state_t                 state;
  logic [WL_GROUPS*8-1:0] wl_buf;
  logic [2:0]             group;
  logic [4:0]             channel;
  logic [15:0]            cnt;
  logic                   done_s1, done_s2, done_s3;
  logic                   done_rise;
  logic [2:0]             group_nxt;
  logic [4:0]             channel_nxt;

  assign done_rise   = done_s2 & ~done_s3;
  assign group_nxt   = group + 3'd1;
  assign channel_nxt = channel + 5'd1;

`ifdef CIM_PAD_SEQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(DONE_TIMEOUT + 1);
  logic [TMR_W-1:0] timer;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wl_buf       <= '0;
      group        <= '0;
      channel      <= '0;
      cnt          <= '0;
      done_s1      <= 1'b0;
      done_s2      <= 1'b0;
      done_s3      <= 1'b0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      res_idx      <= '0;
      res_data     <= '0;
      res_last     <= 1'b0;
      wl_data      <= '0;
      wl_group_sel <= '0;
      wl_latch     <= 1'b0;
      cim_start    <= 1'b0;
      bl_sel       <= '0;
`ifdef CIM_PAD_SEQ_TIMEOUT_EN
      timer        <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      done_s1 <= cim_done;
      done_s2 <= done_s1;
      done_s3 <= done_s2;
`ifdef CIM_PAD_SEQ_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid) begin
            state        <= WL_SETUP;
            wl_buf       <= req_wl;
            group        <= '0;
            cnt          <= '0;
            wl_data      <= req_wl[7:0];
            wl_group_sel <= '0;
            req_ready    <= 1'b0;
            busy         <= 1'b1;
          end
        end
        WL_SETUP: begin
          if (cnt == 16'(SETUP_CYC - 1)) begin
            state    <= WL_LATCH;
            wl_latch <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WL_LATCH: begin
          if (cnt == 16'(LATCH_CYC - 1)) begin
            wl_latch <= 1'b0;
            cnt      <= '0;
            if (group == 3'(WL_GROUPS - 1)) begin
              state     <= START;
              cim_start <= 1'b1;
            end else begin
              state        <= WL_SETUP;
              group        <= group_nxt;
              wl_data      <= wl_buf[int'(group_nxt)*8 +: 8];
              wl_group_sel <= group_nxt;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        START: begin
          cim_start <= 1'b0;
          channel   <= '0;
          state     <= WAIT_DONE;
`ifdef CIM_PAD_SEQ_TIMEOUT_EN
          timer     <= '0;
`endif
        end
        WAIT_DONE: begin
          // Edge-triggered so a done level left over from a previous run cannot start a scan.
          if (done_rise) begin
            state  <= BL_SETTLE;
            bl_sel <= channel;
            cnt    <= '0;
          end
`ifdef CIM_PAD_SEQ_TIMEOUT_EN
          else if (timer == TMR_W'(DONE_TIMEOUT - 1)) begin
            state        <= IDLE;
            timeout_err  <= 1'b1;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            wl_data      <= '0;
            wl_group_sel <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end
        BL_SETTLE: begin
          if (cnt == 16'(BL_SETTLE_CYC - 1)) begin
            state     <= BL_OUT;
            res_valid <= 1'b1;
            res_idx   <= channel;
            res_data  <= bl_data;
            res_last  <= (channel == 5'(BL_CH - 1));
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        BL_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            if (channel == 5'(BL_CH - 1)) begin
              state        <= IDLE;
              req_ready    <= 1'b1;
              busy         <= 1'b0;
              wl_data      <= '0;
              wl_group_sel <= '0;
            end else begin
              state   <= BL_SETTLE;
              channel <= channel_nxt;
              bl_sel  <= channel_nxt;
              cnt     <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cim_pad_sequencer.sv
// Directed bench for cim_pad_sequencer: wordline push, full scan, backpressure, stale done, reset, timeout.
module tb_cim_pad_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_wl;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_idx;
  logic [7:0]  res_data;
  logic        res_last;
  logic        busy;
  logic        timeout_err;
  logic [7:0]  wl_data;
  logic [2:0]  wl_group_sel;
  logic        wl_latch;
  logic        cim_start;
  logic        cim_done;
  logic [4:0]  bl_sel;
  logic [7:0]  bl_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Bitline model: each channel reads back A0 + its index.
  assign bl_data = 8'hA0 + {3'b000, bl_sel};

  cim_pad_sequencer #(.DONE_TIMEOUT(20)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wl(req_wl),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
    .res_data(res_data), .res_last(res_last),
    .busy(busy), .timeout_err(timeout_err),
    .wl_data(wl_data), .wl_group_sel(wl_group_sel), .wl_latch(wl_latch),
    .cim_start(cim_start), .cim_done(cim_done),
    .bl_sel(bl_sel), .bl_data(bl_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_last"}, res_last, 0);
    check({tag, "_wl_data"}, wl_data, 0);
    check({tag, "_wl_group_sel"}, wl_group_sel, 0);
    check({tag, "_wl_latch"}, wl_latch, 0);
    check({tag, "_cim_start"}, cim_start, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  // Starts at a negedge with the DUT idle; ends at the negedge of the first WAIT_DONE cycle.
  task automatic run_wl(input logic [63:0] wl);
    logic [63:0] w;
    w = wl;
    check("accept_ready", req_ready, 1);
    req_wl    = wl;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wl    = ~wl;
    for (int k = 0; k < 16; k++) begin
      check("wl_group_sel", wl_group_sel, 64'(k / 2));
      check("wl_data", wl_data, 64'(w[(k/2)*8 +: 8]));
      check("wl_latch", wl_latch, 64'(k % 2));
      check("wl_cim_start", cim_start, 0);
      @(negedge clk);
    end
    check("cim_start_t17", cim_start, 1);
    @(negedge clk);
    check("cim_start_pulse", cim_start, 0);
    check("busy_wait", busy, 1);
    $display("request wl=%h pushed", wl);
  endtask

  task automatic run_scan(input int hold_idx);
    int n = 0;
    int guard = 0;
    res_ready = 1'b1;
    while (n < 32 && guard < 2000) begin
      @(negedge clk);
      guard++;
      check("no_timeout_scan", timeout_err, 0);
      if (res_valid) begin
        if (int'(res_idx) == hold_idx && res_ready) begin
          res_ready = 1'b0;
          for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_valid", res_valid, 1);
            check("hold_idx", res_idx, 64'(hold_idx));
            check("hold_data", res_data, 64'(8'hA0 + 8'(hold_idx)));
            check("hold_bl_sel", bl_sel, 64'(hold_idx));
          end
          res_ready = 1'b1;
        end
        check("res_idx", res_idx, 64'(n));
        check("res_data", res_data, 64'(8'hA0 + 8'(n)));
        check("res_last", res_last, (n == 31) ? 64'd1 : 64'd0);
        $display("result idx=%0d data=%h last=%0d", res_idx, res_data, res_last);
        n++;
      end
    end
    check("scan_count", 64'(n), 32);
    @(negedge clk);
    check("scan_end_req_ready", req_ready, 1);
    check("scan_end_busy", busy, 0);
    check("scan_end_res_valid", res_valid, 0);
  endtask

  initial begin
    int guard;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wl    = '0;
    res_ready = 1'b0;
    cim_done  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_bl_sel", bl_sel, 0);
    rst = 1'b0;
    @(negedge clk);

    // Wordline sequence followed by a full unthrottled scan.
    run_wl(64'h0807_0605_0403_0201);
    cim_done = 1'b1;
    run_scan(-1);

    // Done still high from the last run: must not start a scan.
    run_wl(64'h1122_3344_5566_7788);
    repeat (10) @(negedge clk);
    check("stale_res_valid", res_valid, 0);
    check("stale_busy", busy, 1);
    check("stale_bl_sel_held", bl_sel, 31);
    cim_done = 1'b0;
    repeat (3) @(negedge clk);
    cim_done = 1'b1;
    run_scan(3);

    // Reset while a latch strobe is high.
    cim_done  = 1'b0;
    req_wl    = 64'hDEAD_BEEF_0BAD_F00D;
    req_valid = 1'b1;
    guard = 0;
    while (!wl_latch && guard < 50) begin
      @(negedge clk);
      req_valid = 1'b0;
      guard++;
    end
    check("saw_wl_latch", wl_latch, 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    check("midrst_bl_sel", bl_sel, 0);
    rst = 1'b0;
    run_wl(64'hA5A5_5A5A_C3C3_3C3C);
    cim_done = 1'b1;
    run_scan(-1);

`ifdef CIM_PAD_SEQ_TIMEOUT_EN
    begin
      int t;
      logic seen_valid;
      cim_done = 1'b0;
      repeat (3) @(negedge clk);
      run_wl(64'h0F0E_0D0C_0B0A_0908);
      t = 1;
      seen_valid = 1'b0;
      while (!timeout_err && t < 100) begin
        @(negedge clk);
        t++;
        if (res_valid) seen_valid = 1'b1;
      end
      check("timeout_cycle", 64'(t), 21);
      check("timeout_busy", busy, 0);
      check("timeout_req_ready", req_ready, 1);
      check("timeout_no_result", seen_valid, 0);
      @(negedge clk);
      check("timeout_pulse", timeout_err, 0);
      $display("timeout after %0d cycles", t);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
